// File: rtl/b32_rco_capture_if.sv
// rtl/b32_rco_capture_if.sv - event stream handshake between capture FIFO and consumer
//
// Purpose : groups the show-ahead event stream of b32_rco_capture.
// Signals : ev_valid - FIFO non-empty, head entry presented on ev_data
//           ev_data  - head entry {kind[1:0], mode[1:0], Q[31:0]}
//           ev_ready - consumer accepts the head entry this cycle
// Modports: master - the capture block (drives valid/data)
//           slave  - the consumer (drives ready)
interface b32_rco_capture_if;
  logic        ev_valid;
  logic [35:0] ev_data;
  logic        ev_ready;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/b32_rco_capture.sv
// rtl/b32_rco_capture.sv - rising-edge capture of counter wrap/load events into a 4-deep FIFO
//
// Purpose : detects rising edges on the full-width ripple-carry (b32_rco[7]) and
//           top-nibble load (b32_load[7]) indicators, tags them with the counter
//           value and mode of the same cycle, and queues them in a 4-entry
//           show-ahead FIFO. Events arriving at a full FIFO are counted.
// Ports   : b32_clk     - clock, rising edge
//           b32_reset   - asynchronous active-high reset
//           b32_Q       - counter value
//           b32_rco     - per-nibble ripple-carry outputs (bit 7 used)
//           b32_load    - per-nibble load indicators (bit 7 used)
//           b32_mode    - counter mode in effect
//           b32_cap_en  - capture enable
//           b32_clear   - synchronous flush of FIFO and drop counter
//           ev          - event stream (master side)
//           fifo_level  - entries held, 0..4
//           drop_cnt    - events lost to a full FIFO, saturating
module b32_rco_capture (
  input  logic                      b32_clk,
  input  logic                      b32_reset,
  input  logic [31:0]               b32_Q,
  input  logic [7:0]                b32_rco,
  input  logic [7:0]                b32_load,
  input  logic [1:0]                b32_mode,
  input  logic                      b32_cap_en,
  input  logic                      b32_clear,
  b32_rco_capture_if.master         ev,
  output logic [2:0]                fifo_level,
  output logic [7:0]                drop_cnt
);

  logic        rco7_q;
  logic        load7_q;
  logic        wrap_evt;
  logic        load_evt;
  logic        push;
  logic        pop;
  logic        full;
  logic        accept;
  logic        drop;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [35:0] entry;
  logic [35:0] mem [0:3];

  // Only the top-nibble indicators are of interest here.
  logic unused_bits;
  assign unused_bits = &{b32_rco[6:0], b32_load[6:0]};

  assign wrap_evt = b32_cap_en & b32_rco[7]  & ~rco7_q;
  assign load_evt = b32_cap_en & b32_load[7] & ~load7_q;

  // kind: 01 wrap, 10 load, 11 both in one cycle -> a single entry
  assign entry = {load_evt, wrap_evt, b32_mode, b32_Q};

  assign push = wrap_evt | load_evt;
  assign pop  = ev.ev_valid & ev.ev_ready;
  // Full/empty come from the explicit level count; the 2-bit pointers are
  // equal both when empty and when full.
  assign full = (fifo_level == 3'd4);

  // A simultaneous pop frees the slot the push needs, even at level 4.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign ev.ev_valid = (fifo_level != 3'd0);
  assign ev.ev_data  = ev.ev_valid ? mem[rd_ptr] : 36'h0;

  always_ff @(posedge b32_clk or posedge b32_reset) begin
    if (b32_reset) begin
      // Edge registers start high so a level already asserted at reset
      // release is not mistaken for an edge.
      rco7_q     <= 1'b1;
      load7_q    <= 1'b1;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_level <= 3'd0;
      drop_cnt   <= 8'd0;
    end else begin
      rco7_q  <= b32_rco[7];
      load7_q <= b32_load[7];
      if (b32_clear) begin
        wr_ptr     <= 2'd0;
        rd_ptr     <= 2'd0;
        fifo_level <= 3'd0;
        drop_cnt   <= 8'd0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 2'd1;
        if (pop)    rd_ptr <= rd_ptr + 2'd1;
        case ({accept, pop})
          2'b10:   fifo_level <= fifo_level + 3'd1;
          2'b01:   fifo_level <= fifo_level - 3'd1;
          default: fifo_level <= fifo_level;
        endcase
        if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage needs no reset: ev_data is masked while the FIFO is empty.
  always_ff @(posedge b32_clk) begin
    if (!b32_clear && accept) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_b32_rco_capture.sv
// tb/tb_b32_rco_capture.sv - scoreboard testbench for b32_rco_capture
module tb_b32_rco_capture;

  logic        b32_clk;
  logic        b32_reset;
  logic [31:0] b32_Q;
  logic [7:0]  b32_rco;
  logic [7:0]  b32_load;
  logic [1:0]  b32_mode;
  logic        b32_cap_en;
  logic        b32_clear;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  b32_rco_capture_if ev ();

  b32_rco_capture dut (
    .b32_clk    (b32_clk),
    .b32_reset  (b32_reset),
    .b32_Q      (b32_Q),
    .b32_rco    (b32_rco),
    .b32_load   (b32_load),
    .b32_mode   (b32_mode),
    .b32_cap_en (b32_cap_en),
    .b32_clear  (b32_clear),
    .ev         (ev.master),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial b32_clk = 1'b0;
  always #5 b32_clk = ~b32_clk;

  int checks   = 0;
  int failures = 0;
  logic [35:0] sb [$];
  int exp_drop = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the consumer takes the head, compare it with the scoreboard.
  initial begin
    forever begin
      @(negedge b32_clk);
      if (!b32_reset && ev.ev_valid && ev.ev_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_entry", ev.ev_data, 36'h0);
        end else begin
          chk("pop_data", ev.ev_data, sb.pop_front());
        end
      end
    end
  end

  // One event pulse: bits high for one sampled edge, then low again.
  task automatic gen_event(input logic w, input logic l, input logic [31:0] q, input logic [1:0] m);
    @(posedge b32_clk); #1;
    b32_rco[7]  = w;
    b32_load[7] = l;
    b32_Q       = q;
    b32_mode    = m;
    if (b32_cap_en && (w || l)) begin
      if (sb.size() < 4 || ev.ev_ready) sb.push_back({l, w, m, q});
      else if (exp_drop < 255) exp_drop++;
    end
    @(posedge b32_clk); #1;
    b32_rco[7]  = 1'b0;
    b32_load[7] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    ev.ev_ready = 1'b1;
    n = 0;
    while (fifo_level != 3'd0 && n < 20) begin
      @(posedge b32_clk); #1;
      n++;
    end
    ev.ev_ready = 1'b0;
    chk({name, "_drained"}, {33'd0, fifo_level}, 36'd0);
    chk({name, "_sb_empty"}, 36'(sb.size()), 36'd0);
  endtask

  initial begin
    b32_reset   = 1'b1;
    b32_Q       = 32'h0;
    b32_rco     = 8'h80;
    b32_load    = 8'h00;
    b32_mode    = 2'b00;
    b32_cap_en  = 1'b1;
    b32_clear   = 1'b0;
    ev.ev_ready = 1'b0;
    repeat (3) @(posedge b32_clk);
    #1;
    chk("reset_level", {33'd0, fifo_level}, 36'd0);
    chk("reset_valid", {35'd0, ev.ev_valid}, 36'd0);
    chk("reset_data",  ev.ev_data, 36'h0);
    chk("reset_drop",  {28'd0, drop_cnt}, 36'd0);
    b32_reset = 1'b0;

    // rco[7] high through reset release: no event
    repeat (3) @(posedge b32_clk);
    #1;
    chk("held_rco_no_event", {35'd0, ev.ev_valid}, 36'd0);
    b32_rco[7] = 1'b0;

    // rise with Q=0 mode=01; valid the cycle after the edge, no bypass with ready high
    ev.ev_ready = 1'b1;
    gen_event(1'b1, 1'b0, 32'h0000_0000, 2'b01);
    chk("latency_valid", {35'd0, ev.ev_valid}, 36'd1);
    chk("latency_data",  ev.ev_data, {2'b01, 2'b01, 32'h0});
    drain("t1");

    // wrap and load together -> one entry of kind 11
    gen_event(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11);
    chk("both_level", {33'd0, fifo_level}, 36'd1);
    chk("both_data",  ev.ev_data, 36'hF_DEAD_BEEF);
    drain("t2");

    // load only -> kind 10
    gen_event(1'b0, 1'b1, 32'h1234_5678, 2'b10);
    chk("load_data", ev.ev_data, 36'hA_1234_5678);
    drain("t3");

    // six wraps, no consumer: 4 kept, 2 dropped
    for (int i = 0; i < 6; i++) gen_event(1'b1, 1'b0, 32'h100 + i, 2'b00);
    chk("six_level", {33'd0, fifo_level}, 36'd4);
    chk("six_drop",  {28'd0, drop_cnt}, 36'd2);
    chk("six_model_drop", 36'(exp_drop), 36'd2);
    drain("t4");

    // full FIFO, event coincides with a pop: accepted, no drop, last out
    for (int i = 0; i < 4; i++) gen_event(1'b1, 1'b0, 32'h200 + i, 2'b01);
    @(posedge b32_clk); #1;
    b32_rco[7]  = 1'b1;
    b32_Q       = 32'h204;
    b32_mode    = 2'b01;
    ev.ev_ready = 1'b1;
    sb.push_back({2'b01, 2'b01, 32'h204});
    @(posedge b32_clk); #1;
    ev.ev_ready = 1'b0;
    b32_rco[7]  = 1'b0;
    chk("full_pushpop_level", {33'd0, fifo_level}, 36'd4);
    chk("full_pushpop_drop",  {28'd0, drop_cnt}, 36'd2);
    drain("t5");

    // 300 events with no consumer: drop counter saturates
    for (int i = 0; i < 300; i++) gen_event(1'b1, 1'b0, 32'h1000 + i, 2'b10);
    chk("sat_drop",  {28'd0, drop_cnt}, 36'hFF);
    chk("sat_level", {33'd0, fifo_level}, 36'd4);

    // clear with a same-cycle event: flushed, event not stored nor counted
    @(posedge b32_clk); #1;
    b32_clear  = 1'b1;
    b32_rco[7] = 1'b1;
    b32_Q      = 32'hCAFE_0000;
    sb.delete();
    exp_drop = 0;
    @(posedge b32_clk); #1;
    b32_clear  = 1'b0;
    b32_rco[7] = 1'b0;
    chk("clear_level", {33'd0, fifo_level}, 36'd0);
    chk("clear_drop",  {28'd0, drop_cnt}, 36'd0);
    chk("clear_valid", {35'd0, ev.ev_valid}, 36'd0);
    repeat (2) @(posedge b32_clk);
    #1;
    chk("clear_no_store", {33'd0, fifo_level}, 36'd0);

    // capture disabled during a rise, then enabled while rco stays high
    b32_cap_en = 1'b0;
    gen_event(1'b1, 1'b0, 32'h5555_5555, 2'b00);
    chk("capen_off_level", {33'd0, fifo_level}, 36'd0);
    @(posedge b32_clk); #1;
    b32_rco[7] = 1'b1;
    @(posedge b32_clk); #1;
    b32_cap_en = 1'b1;
    repeat (2) @(posedge b32_clk);
    #1;
    chk("capen_raise_level", {33'd0, fifo_level}, 36'd0);
    b32_rco[7] = 1'b0;

    // reset mid-operation empties the FIFO at once
    gen_event(1'b1, 1'b0, 32'h7000, 2'b00);
    gen_event(1'b1, 1'b0, 32'h7001, 2'b00);
    chk("pre_reset_level", {33'd0, fifo_level}, 36'd2);
    @(posedge b32_clk); #3;
    b32_reset = 1'b1;
    sb.delete();
    #1;
    chk("async_reset_level", {33'd0, fifo_level}, 36'd0);
    chk("async_reset_valid", {35'd0, ev.ev_valid}, 36'd0);
    chk("async_reset_data",  ev.ev_data, 36'h0);
    @(posedge b32_clk); #1;
    b32_reset = 1'b0;

    // normal operation after reset
    ev.ev_ready = 1'b1;
    gen_event(1'b1, 1'b0, 32'h0BAD_F00D, 2'b10);
    chk("post_reset_data", ev.ev_data, {2'b01, 2'b10, 32'h0BAD_F00D});
    drain("t6");

    repeat (2) @(posedge b32_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
